// File: rtl/branch_resolver.sv
// branch_resolver: registered branch-decision stage with mispredict flush sequencing.
// Optional statistics counters are enabled by defining BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
  parameter int WORDSIZE     = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                is_branch,
  input  logic [2:0]          funct3,
  input  logic                pred_taken,
  input  logic [WORDSIZE-1:0] pc,
  input  logic [WORDSIZE-1:0] target,
  input  logic                flag_equal,
  input  logic                flag_not_equal,
  input  logic                flag_less,
  input  logic                flag_greater,
  input  logic                flag_u_less,
  input  logic                flag_u_greater,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                taken,
  output logic                mispredict,
  output logic                illegal,
  output logic [WORDSIZE-1:0] redirect_pc,
  output logic                flush,
  output logic                dbg_state
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
`endif
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  out_valid_q;
  logic                  taken_q;
  logic                  mispredict_q;
  logic                  illegal_q;
  logic [WORDSIZE-1:0]   redirect_q;

  logic                  taken_d;
  logic                  illegal_d;
  logic                  mispredict_d;
  logic [WORDSIZE-1:0]   redirect_d;
  logic                  accept;

  // Greater-than flags are redundant for RV branch conditions; kept on the port for the flagger.
  logic unused_flags;
  assign unused_flags = flag_greater ^ flag_u_greater;

  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    if (is_branch) begin
      case (funct3)
        3'b000:  taken_d = flag_equal;
        3'b001:  taken_d = flag_not_equal;
        3'b100:  taken_d = flag_less;
        3'b101:  taken_d = !flag_less;
        3'b110:  taken_d = flag_u_less;
        3'b111:  taken_d = !flag_u_less;
        default: illegal_d = 1'b1;
      endcase
    end
    mispredict_d = taken_d ^ pred_taken;
    redirect_d   = taken_d ? target : (pc + WORDSIZE'(4));
  end

  // Handshake: a beat transfers on an edge where valid && ready are both high; a producer
  // holds valid and payload stable until it transfers, ready may change freely.
  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      redirect_q   <= '0;
    end else begin
      if (accept) begin
        out_valid_q  <= 1'b1;
        taken_q      <= taken_d;
        mispredict_q <= mispredict_d;
        illegal_q    <= illegal_d;
        redirect_q   <= redirect_d;
      end else if (out_ready) begin
        out_valid_q  <= 1'b0;
      end

      case (state_q)
        ST_RUN: begin
          if (accept && mispredict_d) begin
            state_q <= ST_FLUSH;
            cnt_q   <= CW'(FLUSH_CYCLES);
          end
        end
        ST_FLUSH: begin
          if (cnt_q == CW'(1)) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign taken       = taken_q;
  assign mispredict  = mispredict_q;
  assign illegal     = illegal_q;
  assign redirect_pc = redirect_q;
  assign flush       = (state_q == ST_FLUSH);
  assign dbg_state   = state_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  // Both counters saturate rather than wrap so long runs never under-report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (accept && is_branch && (branch_cnt_q != 32'hFFFF_FFFF))
        branch_cnt_q <= branch_cnt_q + 32'd1;
      if (accept && mispredict_d && (mispred_cnt_q != 32'hFFFF_FFFF))
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table plus multi-cycle sequences.
module tb_branch_resolver;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, is_branch, pred_taken;
  logic [2:0] funct3;
  logic [W-1:0] pc, target, redirect_pc;
  logic flag_equal, flag_not_equal, flag_less, flag_greater, flag_u_less, flag_u_greater;
  logic out_valid, out_ready, taken, mispredict, illegal, flush, dbg_state;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] branch_count, mispredict_count;
`endif

  branch_resolver #(.WORDSIZE(W), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .funct3(funct3), .pred_taken(pred_taken),
    .pc(pc), .target(target),
    .flag_equal(flag_equal), .flag_not_equal(flag_not_equal), .flag_less(flag_less),
    .flag_greater(flag_greater), .flag_u_less(flag_u_less), .flag_u_greater(flag_u_greater),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .mispredict(mispredict),
    .illegal(illegal), .redirect_pc(redirect_pc), .flush(flush), .dbg_state(dbg_state)
`ifdef BRANCH_RESOLVER_STATS_EN
    , .branch_count(branch_count), .mispredict_count(mispredict_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         is_br;
    logic [2:0]   f3;
    logic         pred;
    logic [W-1:0] pc;
    logic [W-1:0] tgt;
    logic [5:0]   flags; // {eq, ne, lt, gt, ult, ugt}
    logic         e_taken;
    logic         e_mis;
    logic         e_ill;
    logic [W-1:0] e_redir;
  } vec_t;

  vec_t vecs[12];
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    is_branch  = v.is_br;
    funct3     = v.f3;
    pred_taken = v.pred;
    pc         = v.pc;
    target     = v.tgt;
    {flag_equal, flag_not_equal, flag_less, flag_greater, flag_u_less, flag_u_greater} = v.flags;
  endtask

  // Present a beat, wait (bounded) for in_ready, then let it transfer on the next edge.
  task automatic apply_beat(input vec_t v);
    int waited = 0;
    drive(v);
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic br, input logic [2:0] f3, input logic pred,
                              input logic [W-1:0] p, input logic [W-1:0] t, input logic [5:0] fl,
                              input logic et, input logic em, input logic ei, input logic [W-1:0] er);
    vec_t v;
    v.is_br = br; v.f3 = f3; v.pred = pred; v.pc = p; v.tgt = t; v.flags = fl;
    v.e_taken = et; v.e_mis = em; v.e_ill = ei; v.e_redir = er;
    return v;
  endfunction

  vec_t v;
  logic [W-1:0] e;

  initial begin
    vecs[0]  = mk(1'b1, 3'b000, 1'b1, 64'h100, 64'h200, 6'b100000, 1'b1, 1'b0, 1'b0, 64'h200);
    vecs[1]  = mk(1'b1, 3'b110, 1'b1, 64'h100, 64'h300, 6'b000000, 1'b0, 1'b1, 1'b0, 64'h104);
    vecs[2]  = mk(1'b1, 3'b101, 1'b0, 64'h40,  64'h80,  6'b000000, 1'b1, 1'b1, 1'b0, 64'h80);
    vecs[3]  = mk(1'b1, 3'b000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 6'b000000, 1'b0, 1'b1, 1'b0, 64'h0);
    vecs[4]  = mk(1'b1, 3'b001, 1'b1, 64'h200, 64'h280, 6'b010000, 1'b1, 1'b0, 1'b0, 64'h280);
    vecs[5]  = mk(1'b1, 3'b100, 1'b0, 64'h1000, 64'h2000, 6'b001000, 1'b1, 1'b1, 1'b0, 64'h2000);
    vecs[6]  = mk(1'b1, 3'b111, 1'b0, 64'h300, 64'h900, 6'b000010, 1'b0, 1'b0, 1'b0, 64'h304);
    vecs[7]  = mk(1'b1, 3'b010, 1'b0, 64'h400, 64'h800, 6'b111111, 1'b0, 1'b0, 1'b1, 64'h404);
    vecs[8]  = mk(1'b1, 3'b011, 1'b1, 64'h410, 64'h800, 6'b100000, 1'b0, 1'b1, 1'b1, 64'h414);
    vecs[9]  = mk(1'b0, 3'b000, 1'b1, 64'h500, 64'h600, 6'b100000, 1'b0, 1'b1, 1'b0, 64'h504);
    vecs[10] = mk(1'b0, 3'b001, 1'b0, 64'h508, 64'h600, 6'b010000, 1'b0, 1'b0, 1'b0, 64'h50C);
    vecs[11] = mk(1'b1, 3'b101, 1'b1, 64'h700, 64'h780, 6'b001000, 1'b0, 1'b1, 1'b0, 64'h704);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    #22;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_flush", {63'd0, flush}, 64'd0);
    chk("rst_redirect", redirect_pc, 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_state", {63'd0, dbg_state}, 64'd0);

    // Table-driven vectors, one beat at a time with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      exp_q.push_back(v.e_redir);
      apply_beat(v);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("v%0d_taken", i), {63'd0, taken}, {63'd0, v.e_taken});
      chk($sformatf("v%0d_mispredict", i), {63'd0, mispredict}, {63'd0, v.e_mis});
      chk($sformatf("v%0d_illegal", i), {63'd0, illegal}, {63'd0, v.e_ill});
      chk($sformatf("v%0d_redirect", i), redirect_pc, e);
      chk($sformatf("v%0d_flush", i), {63'd0, flush}, {63'd0, v.e_mis});
    end
    repeat (3) step();

    // Flush timing: high for exactly two cycles after the mispredict lands.
    apply_beat(vecs[1]);
    chk("fl_n1_flush", {63'd0, flush}, 64'd1);
    chk("fl_n1_state", {63'd0, dbg_state}, 64'd1);
    chk("fl_n1_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    chk("fl_n2_flush", {63'd0, flush}, 64'd1);
    chk("fl_n2_in_ready", {63'd0, in_ready}, 64'd0);
    chk("fl_n2_out_valid", {63'd0, out_valid}, 64'd0);
    step();
    chk("fl_n3_flush", {63'd0, flush}, 64'd0);
    chk("fl_n3_in_ready", {63'd0, in_ready}, 64'd1);

    // Backpressure: illegal beat held for three cycles, then back-to-back beats.
    out_ready = 1'b0;
    apply_beat(vecs[7]);
    drive(vecs[0]);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("bp%0d_out_valid", c), {63'd0, out_valid}, 64'd1);
      chk($sformatf("bp%0d_illegal", c), {63'd0, illegal}, 64'd1);
      chk($sformatf("bp%0d_taken", c), {63'd0, taken}, 64'd0);
      chk($sformatf("bp%0d_redirect", c), redirect_pc, 64'h404);
      chk($sformatf("bp%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("b2b0_out_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b0_taken", {63'd0, taken}, 64'd1);
    chk("b2b0_illegal", {63'd0, illegal}, 64'd0);
    drive(mk(1'b1, 3'b001, 1'b0, 64'h500, 64'h900, 6'b000000, 1'b0, 1'b0, 1'b0, 64'h504));
    step();
    chk("b2b1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("b2b1_taken", {63'd0, taken}, 64'd0);
    chk("b2b1_redirect", redirect_pc, 64'h504);
    in_valid = 1'b0;
    step();
    chk("b2b_drain_out_valid", {63'd0, out_valid}, 64'd0);

    // Flush ends while the mispredict result is still unconsumed.
    out_ready = 1'b0;
    apply_beat(vecs[11]);
    chk("hold_flush_n1", {63'd0, flush}, 64'd1);
    step();
    step();
    chk("hold_flush_end", {63'd0, flush}, 64'd0);
    chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
    chk("hold_mispredict", {63'd0, mispredict}, 64'd1);
    out_ready = 1'b1;
    #1;
    chk("hold_release_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("hold_consumed", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset in the middle of a flush.
    apply_beat(vecs[2]);
    chk("arst_pre_flush", {63'd0, flush}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_flush", {63'd0, flush}, 64'd0);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_taken", {63'd0, taken}, 64'd0);
    chk("arst_mispredict", {63'd0, mispredict}, 64'd0);
    chk("arst_redirect", redirect_pc, 64'd0);
    #3;
    rst_n = 1'b1;
    step();
    chk("arst_release_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("arst_still_run", {63'd0, flush}, 64'd0);

`ifdef BRANCH_RESOLVER_STATS_EN
    // Five branches (vecs 0,4,6 correct; 1,2 mispredicted) plus one correct non-branch.
    apply_beat(vecs[0]);
    apply_beat(vecs[1]);
    apply_beat(vecs[4]);
    apply_beat(vecs[2]);
    apply_beat(vecs[6]);
    apply_beat(vecs[10]);
    step();
    chk("stats_branch_count", {32'd0, branch_count}, 64'd5);
    chk("stats_mispredict_count", {32'd0, mispredict_count}, 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Registered branch-decision stage directly downstream of the comparison flagger in the RISC-V execute path. Consumes the flagger's comparison flags plus the instruction's funct3 and the fetch-stage prediction, decides taken/not-taken, detects mispredictions and produces a redirect PC. On a misprediction it holds a pipeline-flush pulse for a programmable number of cycles and stalls new input meanwhile.

## Interface
- WORDSIZE, 64, width of PC and target
- FLUSH_CYCLES, 2, cycles `flush` stays high per mispredict (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept input
- is_branch  in  1  instruction is a conditional branch
- funct3  in  3  branch condition code
- pred_taken  in  1  fetch prediction
- pc  in  WORDSIZE  instruction address
- target  in  WORDSIZE  branch target address
- flag_equal, flag_not_equal, flag_less, flag_greater, flag_u_less, flag_u_greater  in  1 each  flagger outputs for this instruction
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- taken  out  1  resolved direction
- mispredict  out  1  taken ≠ pred_taken
- illegal  out  1  reserved funct3 on a branch
- redirect_pc  out  WORDSIZE  correct next PC (valid when mispredict)
- flush  out  1  pipeline flush request

## Operation
- Condition map (is_branch=1): 000 BEQ→flag_equal; 001 BNE→flag_not_equal; 100 BLT→flag_less; 101 BGE→!flag_less; 110 BLTU→flag_u_less; 111 BGEU→!flag_u_less; 010/011 → taken=0, illegal=1.
- is_branch=0: taken=0, illegal=0; mispredict still computed (pred_taken=1 on non-branch is a mispredict).
- redirect_pc = taken ? target : pc+4, modulo 2^WORDSIZE (pc+4 wraps, no carry out).
- FSM states RUN, FLUSH. RUN→FLUSH when a beat with mispredict=1 is captured into the output register; counter loaded with FLUSH_CYCLES. FLUSH decrements each cycle; at count 1 → RUN.
- flush=1 exactly while state=FLUSH.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Output register: loads on in_valid&&in_ready; out_valid clears on out_valid&&out_ready with no new load.
- Result fields hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset (async assert, sync release): out_valid=0, taken=0, mispredict=0, illegal=0, redirect_pc=0, flush=0, state=RUN, counter=0; in_ready=1 after release.
- Latency: accept in cycle N → out_valid and result in cycle N+1.
- Throughput: one beat per cycle in RUN with out_ready=1.
- Mispredict accepted cycle N: out_valid, mispredict, flush high from N+1; flush high N+1…N+FLUSH_CYCLES; in_ready low over same span; in_ready may rise N+FLUSH_CYCLES+1.
- Output consumption is independent of flush: out_ready may accept the mispredict result during FLUSH.
- FLUSH ending while out_valid=1 and out_ready=0: state returns to RUN, in_ready stays low until result consumed.
- Simultaneous accept+consume: new beat replaces old in same edge, out_valid stays 1.
- Reset mid-FLUSH: flush drops immediately (async), counter cleared.

## Configuration
- BRANCH_RESOLVER_STATS_EN defined: adds outputs branch_count[31:0] and mispredict_count[31:0]; increment on each accepted beat with is_branch=1 / with mispredict=1 respectively; saturate at 0xFFFF_FFFF; reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset: rst_n=0 mid-stream → all outputs 0, in_ready=1 after release.
- BEQ, flag_equal=1, pred_taken=1, pc=0x100, target=0x200 → N+1: out_valid=1, taken=1, mispredict=0, flush=0.
- BLTU, flag_u_less=0, pred_taken=1, pc=0x100 → taken=0, mispredict=1, redirect_pc=0x104, flush high 2 cycles, in_ready low 2 cycles.
- BGE, flag_less=0, pred_taken=0, target=0x80 → taken=1, redirect_pc=0x80; pc=0xFFFF_FFFF_FFFF_FFFC BEQ not taken mispredicted → redirect_pc=0.
- funct3=010, is_branch=1 → illegal=1, taken=0; out_ready=0 for 3 cycles → outputs stable, in_ready=0, then one beat per cycle after out_ready=1.
- With BRANCH_RESOLVER_STATS_EN: 5 branches, 2 mispredicted → branch_count=5, mispredict_count=2.
